// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 board I/O responder: FSM state encoding,
// default I/O address and a helper that widens the switch bank to a bus word.
package slc3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ACK = 2'd1,
    WR_ACK = 2'd2,
    PAUSED = 2'd3
  } io_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  function automatic logic [15:0] sw_to_word(input logic [9:0] sw);
    return {6'b000000, sw};
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes and debounces one active-low push button and emits a one-cycle
// pulse on each accepted press. SYNC_STAGES must be at least 2.
module button_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_n,
  output logic pulse,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          count;
  logic                   stable_prev;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_n};
    end
  end

  // Stable value flips only after DEBOUNCE_CYC consecutive disagreeing cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count  <= '0;
      stable <= 1'b1;
    end else if (sync_out != stable) begin
      if (count == LAST) begin
        count  <= '0;
        stable <= sync_out;
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      count <= '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stable_prev <= 1'b1;
      pulse       <= 1'b0;
    end else begin
      stable_prev <= stable;
      pulse       <= stable_prev & ~stable;
    end
  end

endmodule

// File: rtl/slc3_io_responder.sv
// Board-side responder for the SLC-3: button conditioning, memory-mapped
// switch/hex I/O with one-cycle acknowledge, and the pause/continue handshake.
module slc3_io_responder
  import slc3_pkg::*;
#(
  parameter logic [15:0] IO_ADDR      = IO_ADDR_DEFAULT,
  parameter int          DEBOUNCE_CYC = 4,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [9:0]  SW,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        io_ack,
  input  logic        pause_req,
  input  logic [9:0]  pause_code,
  output logic        pause_ack,
  output logic        run_pulse,
  output logic [15:0] HEX_data,
  output logic [9:0]  LED
);

  io_state_t state, state_next;
  logic      cont_pulse;
  logic      hit, wr_go, rd_go;
  logic      we_armed, oe_armed;
  logic      load_hex, load_rd, load_led, clear_led, ack_next, pack_next;

  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run (
    .Clk(Clk), .Reset(Reset), .btn_n(Run), .pulse(run_pulse), .stable()
  );

  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cont (
    .Clk(Clk), .Reset(Reset), .btn_n(Continue), .pulse(cont_pulse), .stable()
  );

  // A strobe is armed while high; accepting an access disarms it until it rises again.
  assign hit   = (ADDR == IO_ADDR);
  assign wr_go = hit & ~WE & we_armed;
  assign rd_go = hit & ~OE & oe_armed;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_hex   = 1'b0;
    load_rd    = 1'b0;
    load_led   = 1'b0;
    clear_led  = 1'b0;
    ack_next   = 1'b0;
    pack_next  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_go) begin
          state_next = WR_ACK;
          load_hex   = 1'b1;
          ack_next   = 1'b1;
        end else if (rd_go) begin
          state_next = RD_ACK;
          load_rd    = 1'b1;
          ack_next   = 1'b1;
        end else if (pause_req) begin
          state_next = PAUSED;
          load_led   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RD_ACK, WR_ACK: state_next = IDLE;
      PAUSED: begin
        // Run overrides Continue and never produces pause_ack.
        if (run_pulse) begin
          state_next = IDLE;
          clear_led  = 1'b1;
        end else if (cont_pulse) begin
          state_next = IDLE;
          clear_led  = 1'b1;
          pack_next  = 1'b1;
        end else begin
          state_next = PAUSED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      we_armed <= 1'b1;
      oe_armed <= 1'b1;
    end else begin
      if (WE) begin
        we_armed <= 1'b1;
      end else if (load_hex | load_rd) begin
        we_armed <= 1'b0;
      end else begin
        we_armed <= we_armed;
      end
      if (OE) begin
        oe_armed <= 1'b1;
      end else if (load_hex | load_rd) begin
        oe_armed <= 1'b0;
      end else begin
        oe_armed <= oe_armed;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      HEX_data    <= 16'h0000;
      Data_to_CPU <= 16'h0000;
      LED         <= 10'h000;
      io_ack      <= 1'b0;
      pause_ack   <= 1'b0;
    end else begin
      io_ack    <= ack_next;
      pause_ack <= pack_next;
      if (load_hex) begin
        HEX_data <= Data_from_CPU;
      end
      if (load_rd) begin
        Data_to_CPU <= sw_to_word(SW);
      end
      if (load_led) begin
        LED <= pause_code;
      end else if (clear_led) begin
        LED <= 10'h000;
      end
    end
  end

endmodule

// File: tb/tb_slc3_io_responder.sv
// Self-checking bench for slc3_io_responder: table-driven access vectors,
// hand-written button/pause sequences and a randomized access phase vs a model.
module tb_slc3_io_responder;

  logic        Clk = 1'b0;
  logic        Reset, Run, Continue, OE, WE, pause_req;
  logic [9:0]  SW, pause_code, LED;
  logic [15:0] ADDR, Data_from_CPU, Data_to_CPU, HEX_data;
  logic        io_ack, pause_ack, run_pulse;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  slc3_io_responder dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .SW(SW),
    .ADDR(ADDR), .OE(OE), .WE(WE), .Data_from_CPU(Data_from_CPU),
    .Data_to_CPU(Data_to_CPU), .io_ack(io_ack), .pause_req(pause_req),
    .pause_code(pause_code), .pause_ack(pause_ack), .run_pulse(run_pulse),
    .HEX_data(HEX_data), .LED(LED)
  );

  typedef struct {
    logic [15:0] addr;
    logic        oe;
    logic        we;
    logic [9:0]  sw;
    logic [15:0] din;
    logic        ack;
    logic [15:0] dout;
    logic [15:0] hex;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {Data_to_CPU, HEX_data}, 32'h0);
    chk({nm, "_ctl"}, {19'h0, LED, io_ack, pause_ack, run_pulse}, 32'h0);
  endtask

  // Press Continue (held 10 cycles) and wait for pause_ack; drop pause_req when it arrives.
  task automatic continue_release_pause(input string nm, input int exp_edge);
    int acks = 0;
    int ack_edge = -1;
    Continue = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (pause_ack) begin
        acks++;
        if (ack_edge < 0) begin
          ack_edge  = i;
          pause_req = 1'b0;
          chk({nm, "_led_cleared"}, {22'h0, LED}, 32'h0);
        end
      end
      if (i == 10) Continue = 1'b1;
    end
    chk({nm, "_ack_count"}, acks, 32'd1);
    chk({nm, "_ack_edge"}, ack_edge, exp_edge);
  endtask

  initial begin
    logic [15:0] m_hex, m_dout;
    logic        m_busy, m_we_arm, m_oe_arm, acc, hit;
    int          pulses, first_edge, acks, led_bad;

    Reset = 1'b1; Run = 1'b1; Continue = 1'b1; OE = 1'b1; WE = 1'b1;
    SW = 10'h000; ADDR = 16'h0000; Data_from_CPU = 16'h0000;
    pause_req = 1'b0; pause_code = 10'h000;
    step(); step();
    chk_all_zero("reset_state");
    Reset = 1'b0;
    step();

    // Reset in the middle of a Run debounce discards the pending press.
    Run = 1'b0;
    step(); step();
    Reset = 1'b1;
    #1;
    chk_all_zero("reset_mid_debounce");
    Run = 1'b1;
    step(); step();
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (run_pulse) pulses++;
    end
    chk("no_pulse_after_reset", pulses, 32'd0);

    tbl[0] = '{16'hFFFF, 1'b0, 1'b1, 10'h05A, 16'h0000, 1'b1, 16'h005A, 16'h0000};
    tbl[1] = '{16'hFFFF, 1'b0, 1'b1, 10'h05A, 16'h0000, 1'b0, 16'h005A, 16'h0000};
    tbl[2] = '{16'hFFFF, 1'b0, 1'b1, 10'h111, 16'h0000, 1'b0, 16'h005A, 16'h0000};
    tbl[3] = '{16'hFFFF, 1'b1, 1'b1, 10'h111, 16'h0000, 1'b0, 16'h005A, 16'h0000};
    tbl[4] = '{16'h0010, 1'b0, 1'b1, 10'h222, 16'h0000, 1'b0, 16'h005A, 16'h0000};
    tbl[5] = '{16'hFFFF, 1'b1, 1'b1, 10'h222, 16'h0000, 1'b0, 16'h005A, 16'h0000};
    tbl[6] = '{16'hFFFF, 1'b0, 1'b0, 10'h333, 16'h1234, 1'b1, 16'h005A, 16'h1234};
    tbl[7] = '{16'hFFFF, 1'b1, 1'b1, 10'h333, 16'h5555, 1'b0, 16'h005A, 16'h1234};
    tbl[8] = '{16'h0010, 1'b1, 1'b0, 10'h333, 16'hABCD, 1'b0, 16'h005A, 16'h1234};
    tbl[9] = '{16'hFFFF, 1'b0, 1'b1, 10'h3FF, 16'h0000, 1'b1, 16'h03FF, 16'h1234};
    for (int i = 0; i < 10; i++) begin
      ADDR = tbl[i].addr; OE = tbl[i].oe; WE = tbl[i].we;
      SW = tbl[i].sw; Data_from_CPU = tbl[i].din;
      step();
      chk($sformatf("vec%0d_ack", i), {31'h0, io_ack}, {31'h0, tbl[i].ack});
      chk($sformatf("vec%0d_dout", i), {16'h0, Data_to_CPU}, {16'h0, tbl[i].dout});
      chk($sformatf("vec%0d_hex", i), {16'h0, HEX_data}, {16'h0, tbl[i].hex});
    end
    OE = 1'b1; WE = 1'b1; ADDR = 16'h0000;
    step();

    // Long pause: LED shows the code and only a Continue press releases it.
    pause_req = 1'b1; pause_code = 10'h003;
    step();
    chk("pause_led", {22'h0, LED}, 32'h003);
    acks = 0; led_bad = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (pause_ack) acks++;
      if (LED !== 10'h003) led_bad++;
    end
    chk("pause_no_early_ack", acks, 32'd0);
    chk("pause_led_held", led_bad, 32'd0);
    continue_release_pause("continue", 8);

    // Paused again: a 3-cycle Continue glitch must not release, then Run exits.
    pause_req = 1'b1; pause_code = 10'h2AA;
    step();
    chk("pause2_led", {22'h0, LED}, 32'h2AA);
    Continue = 1'b0;
    step(); step(); step();
    Continue = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pause_ack) acks++;
    end
    chk("glitch_no_ack", acks, 32'd0);
    chk("glitch_led_kept", {22'h0, LED}, 32'h2AA);

    Run = 1'b0;
    pulses = 0; first_edge = -1; acks = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (run_pulse) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = i;
          pause_req  = 1'b0;
        end
      end
      if (pause_ack) acks++;
      if (first_edge > 0 && i == first_edge + 1)
        chk("run_clears_led", {22'h0, LED}, 32'h0);
      if (i == 20) Run = 1'b1;
    end
    chk("run_latency", first_edge, 32'd7);
    chk("run_single_pulse", pulses, 32'd1);
    chk("run_no_pause_ack", acks, 32'd0);

    // Continue pressed in IDLE is forgotten.
    Continue = 1'b0;
    for (int i = 0; i < 12; i++) step();
    Continue = 1'b1;
    for (int i = 0; i < 12; i++) step();
    pause_req = 1'b1; pause_code = 10'h001;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (pause_ack) acks++;
    end
    chk("idle_continue_forgotten", acks, 32'd0);
    chk("pause3_led", {22'h0, LED}, 32'h001);
    continue_release_pause("continue3", 8);

    // Randomized accesses checked against a transaction-level model.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_hex = 16'h0; m_dout = 16'h0; m_busy = 1'b0; m_we_arm = 1'b1; m_oe_arm = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ADDR = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFE)) : 16'hFFFF;
      OE = 1'($urandom_range(0, 1));
      WE = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      SW = 10'($urandom);
      Data_from_CPU = 16'($urandom);
      hit = (ADDR == 16'hFFFF);
      acc = 1'b0;
      if (!m_busy && hit && !WE && m_we_arm) begin
        m_hex = Data_from_CPU;
        acc   = 1'b1;
      end else if (!m_busy && hit && !OE && m_oe_arm) begin
        m_dout = {6'h00, SW};
        acc    = 1'b1;
      end
      m_we_arm = WE ? 1'b1 : (acc ? 1'b0 : m_we_arm);
      m_oe_arm = OE ? 1'b1 : (acc ? 1'b0 : m_oe_arm);
      m_busy   = acc;
      step();
      chk("rand_ack", {31'h0, io_ack}, {31'h0, m_busy});
      chk("rand_dout", {16'h0, Data_to_CPU}, {16'h0, m_dout});
      chk("rand_hex", {16'h0, HEX_data}, {16'h0, m_hex});
      chk("rand_idle_led", {21'h0, LED, pause_ack}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
